data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Multi-cycle data-memory slave: the responder end of the CPU load/store path.
- Accepts one word read or write per request on a ready/ack handshake.
- Models a configurable access latency, so later pipelined/stalling CPU work can use a non-ideal memory.
- Sits between the CPU memory stage (initiator) and a word-addressed storage array held inside the block.

Parameters:
DEPTH, 32, number of 32-bit words in the array (power of two, 4..1024)
LATENCY, 2, cycles from request acceptance to ack (1..15)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
req_i  input  1  request valid from initiator
we_i  input  1  1 = write, 0 = read; sampled at acceptance
addr_i  input  32  byte address; sampled at acceptance
data_i  input  32  write data; sampled at acceptance
ready_o  output  1  responder can accept a request this cycle
ack_o  output  1  one-cycle completion strobe
data_o  output  32  read data, valid while ack_o=1
err_o  output  1  access error, valid while ack_o=1

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE; ready_o=0, ack_o=0, err_o=0, data_o=0, counter=0.
  - Array contents are not cleared and are undefined until written.
- ready_o, ack_o, err_o and data_o are all registered.
- ready_o rises on the first rising edge after rst_i deasserts.
- Acceptance happens at edge k when req_i=1 and ready_o=1:
  - we_i, addr_i and data_i are captured.
  - Request inputs after edge k are ignored until the next acceptance.
- State machine:
  - IDLE: ready_o=1. On acceptance go to BUSY, cnt=LATENCY-1, ready_o<=0.
  - BUSY: if cnt==0 go to RESP and assert ack_o at this edge (edge k+LATENCY); otherwise cnt<=cnt-1.
  - RESP: ack_o=1 for exactly one cycle. Next edge goes to IDLE with ack_o<=0 and ready_o<=1.
- Throughput: one request per LATENCY+2 cycles. With LATENCY=1, requests can be accepted at k, k+3, k+6, ...
- Error check on the captured address: err if addr[1:0]!=0 or addr[31:2]>=DEPTH.
  - Error: ack with err_o=1, data_o=0, no array write.
- Write with no error: array[addr[31:2]] updated at the edge where ack_o rises. data_o keeps its previous value; err_o=0.
- Read with no error: data_o<=array[addr[31:2]] at the edge where ack_o rises.
  - data_o holds that value until the next read or error ack.
- A read accepted after a write ack always returns the written data (no forwarding hazard; accesses are serialized).
- req_i held high during BUSY/RESP is ignored. A request dropped before ready_o=1 is never seen.
- ack_o is never asserted without a prior acceptance, and never twice for one acceptance.
- Reset mid-operation: the pending request is discarded, with no ack and no array write. The block returns to the reset state.
- Word index is addr[2+$clog2(DEPTH)-1:2]; upper bits are used only for the range check.
- Counter width is 4 bits; LATENCY outside 1..15 is an elaboration error.

Decomposition:
- Shared package (mem_pkg):
  - state enum {IDLE, BUSY, RESP}
  - WORD_W=32
  - helper constant for byte-offset width (2)
- One sub-module: mem_array_1rw. It holds the DEPTH x 32 synchronous array with one port: write-enable, index, wdata, rdata registered.
- FSM, counter and error check stay in the top.

Test Plan:
1. Reset release, LATENCY=2: hold rst_i=0 for 3 cycles, release -> ready_o=0 during reset; ready_o=1 one edge after release; ack_o=0, data_o=0 throughout.
2. Write then read, LATENCY=2:
   - Write addr=0x10, data=0xDEADBEEF accepted at edge k -> ack_o=1 at edge k+2 only, err_o=0, ready_o=1 at k+3.
   - Read addr=0x10 -> ack with data_o=0xDEADBEEF.
3. Misaligned write: write addr=0x13, data=0x12345678 -> ack with err_o=1, data_o=0. A following read of 0x10 returns 0xDEADBEEF (unchanged).
4. Out of range, DEPTH=32: read addr=0x80 -> ack with err_o=1, data_o=0.
5. LATENCY=1 back-to-back with req_i held high:
   - Four writes to 0x0, 0x4, 0x8, 0xC -> accepts at k, k+3, k+6, k+9; exactly four acks at k+1, k+4, k+7, k+10.
   - Read-back returns each written value.
6. Reset mid-operation:
   - Write addr=0x20, data=0xA5A5A5A5 accepted, then rst_i=0 for one cycle before ack -> no ack.
   - After reset: write 0x20=0x1, then read 0x20 -> data_o=0x00000001.
   - A read of 0x24 (never written) still acks, err_o=0, data_o not checked (contents undefined).

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package mem_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response bus between the CPU memory stage (master) and the responder (slave).
interface data_memory_responder_if;
    import mem_pkg::*;

    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              ready;
    logic              ack;
    logic [WORD_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  ready, ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, ack, rdata, err
    );

endinterface

// File: rtl/data_memory_responder_array.sv
// Single-port DEPTH x 32 storage with a registered read port.
// The read register doubles as the responder's data output, so it also
// carries the reset value and the clear used on error responses.
module mem_array_1rw
    import mem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic              clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wdata;
        end
    end

    // Read register: cleared on reset/error, loaded on reads, held on writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle word-wide data-memory responder with configurable access latency.
//
// state | meaning
// IDLE  | ready high, waiting for req
// BUSY  | request captured, counting down the access latency
// RESP  | ack high for one cycle, data/err valid
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    data_memory_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("data_memory_responder: LATENCY must be in 1..15");
    end

    if (DEPTH < 4 || DEPTH > 1024 || (1 << IDX_W) != DEPTH) begin : g_bad_depth
        $error("data_memory_responder: DEPTH must be a power of two in 4..1024");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               capture;
    logic               mem_en;
    logic               mem_clr;

    logic               we_q;
    logic [WORD_W-1:0]  addr_q;
    logic [WORD_W-1:0]  wdata_q;
    logic               addr_err;
    logic [IDX_W-1:0]   idx;

    // Range and alignment check runs on the captured address only.
    assign addr_err = (addr_q[BYTE_OFF_W-1:0] != '0) ||
                      (addr_q[WORD_W-1:BYTE_OFF_W] >= (WORD_W-BYTE_OFF_W)'(DEPTH));
    assign idx      = addr_q[BYTE_OFF_W +: IDX_W];

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Request capture at acceptance; held until the next acceptance.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    // Next-state logic; the array access fires on the edge where ack rises.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        ack_d   = 1'b0;
        err_d   = err_q;
        capture = 1'b0;
        mem_en  = 1'b0;
        mem_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (ready_q && bus.req) begin
                    capture = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    ready_d = 1'b0;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    err_d   = addr_err;
                    mem_en  = !addr_err;
                    mem_clr = addr_err;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_array_1rw #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (mem_en),
        .we    (we_q),
        .clr   (mem_clr),
        .idx   (idx),
        .wdata (wdata_q),
        .rdata (bus.rdata)
    );

    assign bus.ready = ready_q;
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench: two responders (LATENCY=2 and LATENCY=1) on a shared clock/reset,
// a selector steers stimulus to one of them, and a scoreboard checks every ack.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_v;
    logic        we_v;
    logic [31:0] addr_v;
    logic [31:0] wdata_v;

    always #5 clk = ~clk;

    data_memory_responder_if bus2 ();
    data_memory_responder_if bus1 ();

    assign bus2.req   = req_v & ~sel;
    assign bus2.we    = we_v;
    assign bus2.addr  = addr_v;
    assign bus2.wdata = wdata_v;
    assign bus1.req   = req_v & sel;
    assign bus1.we    = we_v;
    assign bus1.addr  = addr_v;
    assign bus1.wdata = wdata_v;

    data_memory_responder #(.DEPTH(32), .LATENCY(2)) u_dut2 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus2.slave)
    );

    data_memory_responder #(.DEPTH(32), .LATENCY(1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus1.slave)
    );

    logic        ready_m;
    logic        ack_m;
    logic        err_m;
    logic [31:0] data_m;
    assign ready_m = sel ? bus1.ready : bus2.ready;
    assign ack_m   = sel ? bus1.ack   : bus2.ack;
    assign err_m   = sel ? bus1.err   : bus2.err;
    assign data_m  = sel ? bus1.rdata : bus2.rdata;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
        int          acc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every ack must match the oldest outstanding acceptance.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ack_m === 1'b1) begin
            exp_t e;
            ack_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ack: got ack with no outstanding request, expected none (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("ack_err", {31'd0, err_m}, {31'd0, e.err});
                if (e.chk) check("ack_data", data_m, e.data);
                check("ack_latency", 32'(cyc - e.acc), sel ? 32'd1 : 32'd2);
            end
        end
    end

    task automatic push_exp(input logic err, input logic chk, input logic [31:0] data);
        exp_t e;
        e.err  = err;
        e.chk  = chk;
        e.data = data;
        e.acc  = cyc;
        sb.push_back(e);
    endtask

    // One request through acceptance, ack, and return to ready.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic err, input logic chk, input logic [31:0] exp);
        bit got;
        we_v = we; addr_v = addr; wdata_v = wdata; req_v = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ready_m === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin
            checks++; errors++; req_v = 1'b0;
            $display("FAIL accept_timeout: got ready=0 for 20 cycles, expected ready=1");
            return;
        end
        @(posedge clk);
        #1;
        push_exp(err, chk, exp);
        req_v = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack_m === 1'b1) begin got = 1'b1; break; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got no ack in 40 cycles, expected ack");
            return;
        end
        check("ready_during_ack", {31'd0, ready_m}, 32'd0);
        @(negedge clk);
        check("ready_after_ack", {31'd0, ready_m}, 32'd1);
        check("ack_one_cycle", {31'd0, ack_m}, 32'd0);
    endtask

    vec_t        vecs[10];
    logic [31:0] wvals[4];
    int          acc_cyc[4];
    int          base;
    bit          got;

    initial begin
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0};
        vecs[1] = '{1'b0, 32'h10, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 32'h13, 32'h12345678, 1'b1, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h10, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 32'h80, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 32'h7C, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 32'h7C, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D};
        vecs[7] = '{1'b0, 32'h7E, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[8] = '{1'b1, 32'h80, 32'h11111111, 1'b1, 1'b1, 32'h0};
        vecs[9] = '{1'b0, 32'h7C, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D};
        wvals   = '{32'h01020304, 32'hA0B0C0D0, 32'h55AA55AA, 32'hFFFF0000};

        rst_n = 1'b0; sel = 1'b0; req_v = 1'b0; we_v = 1'b0; addr_v = '0; wdata_v = '0;

        // Reset held for 3 cycles: all outputs low.
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", {31'd0, bus2.ready}, 32'd0);
            check("rst_ack", {31'd0, bus2.ack}, 32'd0);
            check("rst_data", bus2.rdata, 32'd0);
            check("rst_ready_l1", {31'd0, bus1.ready}, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {31'd0, ready_m}, 32'd0);
        @(negedge clk);
        check("ready_after_release", {31'd0, ready_m}, 32'd1);
        check("ack_after_release", {31'd0, ack_m}, 32'd0);
        check("data_after_release", data_m, 32'd0);

        // Table-driven single transactions, LATENCY=2.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].chk, vecs[i].exp);
        end

        // LATENCY=1, req held high across four back-to-back writes.
        sel = 1'b1;
        @(negedge clk);
        base = ack_cnt;
        we_v = 1'b1; addr_v = 32'h0; wdata_v = wvals[0]; req_v = 1'b1;
        for (int n = 0; n < 4; n++) begin
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (ready_m === 1'b1) begin got = 1'b1; break; end
                @(negedge clk);
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL b2b_accept_timeout: got ready=0 for 20 cycles, expected ready=1");
                break;
            end
            @(posedge clk);
            #1;
            acc_cyc[n] = cyc;
            push_exp(1'b0, 1'b1, 32'h0);
            if (n < 3) begin
                addr_v  = 32'(4 * (n + 1));
                wdata_v = wvals[n + 1];
            end
        end
        req_v = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b_ack_count", 32'(ack_cnt - base), 32'd4);
        for (int n = 1; n < 4; n++) begin
            check("b2b_accept_spacing", 32'(acc_cyc[n] - acc_cyc[n - 1]), 32'd3);
        end
        for (int n = 0; n < 4; n++) begin
            issue(1'b0, 32'(4 * n), 32'h0, 1'b0, 1'b1, wvals[n]);
        end

        // Reset during BUSY discards the pending write, LATENCY=2.
        sel = 1'b0;
        @(negedge clk);
        we_v = 1'b1; addr_v = 32'h20; wdata_v = 32'hA5A5A5A5; req_v = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ready_m === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL midrst_accept_timeout: got ready=0 for 20 cycles, expected ready=1");
        end
        @(posedge clk);
        #1;
        req_v = 1'b0;
        base = ack_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, ready_m}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_ack", 32'(ack_cnt - base), 32'd0);
        issue(1'b1, 32'h20, 32'h00000001, 1'b0, 1'b1, 32'h0);
        issue(1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h00000001);
        issue(1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
